bp_nbf_io_responder: RTL and testbench

BP_NBF_IO_RESPONDER -- requirements
Module: bp_nbf_io_responder

---
 rtl/bp_nbf_io_responder.sv | 160 ++++++++++++++++
 tb/tb_bp_nbf_io_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_nbf_io_responder.sv
// Memory-mapped I/O responder: a small 64-bit register file behind a fixed
// address window, answering one command per cycle through a one-entry
// response buffer.
//
// Ports
//   clk_i, reset_i        clock; asynchronous active-low reset
//   io_cmd_*_i            command: type (0 rd, 1 wr, 2 done-wr, 3 unsupported),
//                         byte address, log2 size, LSB-justified data, tag
//   io_cmd_v_i            command valid
//   io_cmd_yumi_o         command consumed this cycle (combinational)
//   io_resp_*_o           response: echoed type/addr/size/payload, read data,
//                         error flag
//   io_resp_v_o           response valid
//   io_resp_ready_and_i   response ready
//   done_o                sticky flag set by a successful done-write
//   cmd_count_o           saturating count of accepted commands
module bp_nbf_io_responder #(
  parameter int unsigned els_p = 16,
  parameter int unsigned paddr_width_p = 40,
  parameter logic [paddr_width_p-1:0] base_addr_p = 40'h00_0010_0000,
  parameter int unsigned payload_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 io_cmd_type_i,
  input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
  input  logic [1:0]                 io_cmd_size_i,
  input  logic [63:0]                io_cmd_data_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_yumi_o,
  output logic [1:0]                 io_resp_type_o,
  output logic [paddr_width_p-1:0]   io_resp_addr_o,
  output logic [1:0]                 io_resp_size_o,
  output logic [63:0]                io_resp_data_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic                       io_resp_err_o,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_ready_and_i,
  output logic                       done_o,
  output logic [31:0]                cmd_count_o
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam logic [paddr_width_p-1:0] win_bytes_lp = paddr_width_p'(8 * els_p);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]                 typ;
    logic [paddr_width_p-1:0]   addr;
    logic [1:0]                 size;
    logic [63:0]                data;
    logic [payload_width_p-1:0] payload;
    logic                       err;
  } resp_s;

  state_e                   state_r, state_n;
  logic                     armed_r;
  logic                     resp_hs_c;
  logic [paddr_width_p-1:0] offset_c;
  logic                     in_win_c, misalign_c, err_c, is_read_c, is_write_c;
  logic [lg_els_lp-1:0]     idx_c;
  logic [5:0]               bit_off_c;
  logic [63:0]              size_mask_c, wmask_c, wdata_c, entry_c, rdata_c;
  logic [63:0]              mem_r [els_p];
  resp_s                    resp_r, resp_n;
  logic                     done_r;
  logic [31:0]              count_r;

  // Command decode: window, alignment, byte lane masks and read/merge data
  always_comb begin
    offset_c    = io_cmd_addr_i - base_addr_p;
    in_win_c    = offset_c < win_bytes_lp;
    idx_c       = io_cmd_addr_i[3 +: lg_els_lp];
    bit_off_c   = {io_cmd_addr_i[2:0], 3'b000};
    size_mask_c = 64'h0000_0000_0000_00FF;
    misalign_c  = 1'b0;
    case (io_cmd_size_i)
      2'd0: begin size_mask_c = 64'h0000_0000_0000_00FF; misalign_c = 1'b0;                end
      2'd1: begin size_mask_c = 64'h0000_0000_0000_FFFF; misalign_c = io_cmd_addr_i[0];    end
      2'd2: begin size_mask_c = 64'h0000_0000_FFFF_FFFF; misalign_c = |io_cmd_addr_i[1:0]; end
      2'd3: begin size_mask_c = 64'hFFFF_FFFF_FFFF_FFFF; misalign_c = |io_cmd_addr_i[2:0]; end
      default: ;
    endcase
    err_c      = ~in_win_c | misalign_c | (io_cmd_type_i == 2'd3);
    is_read_c  = ~err_c & (io_cmd_type_i == 2'd0);
    is_write_c = ~err_c & ((io_cmd_type_i == 2'd1) | (io_cmd_type_i == 2'd2));
    entry_c    = mem_r[idx_c];
    // Aligned accesses never cross the entry, so the shifted masks stay in range
    rdata_c    = (entry_c >> bit_off_c) & size_mask_c;
    wmask_c    = size_mask_c << bit_off_c;
    wdata_c    = (io_cmd_data_i & size_mask_c) << bit_off_c;
  end

  // Response buffer FSM: accept when empty or when the held response drains
  always_comb begin
    state_n       = state_r;
    resp_hs_c     = (state_r == FULL) & io_resp_ready_and_i;
    io_cmd_yumi_o = armed_r & io_cmd_v_i & ((state_r == EMPTY) | resp_hs_c);
    case (state_r)
      EMPTY: if (io_cmd_yumi_o) state_n = FULL;
      FULL:  if (resp_hs_c && !io_cmd_yumi_o) state_n = EMPTY;
    endcase
  end

  // Next response contents, captured on the accept edge
  always_comb begin
    resp_n         = '0;
    resp_n.typ     = io_cmd_type_i;
    resp_n.addr    = io_cmd_addr_i;
    resp_n.size    = io_cmd_size_i;
    resp_n.data    = is_read_c ? rdata_c : 64'd0;
    resp_n.payload = io_cmd_payload_i;
    resp_n.err     = err_c;
  end

  // State, response buffer, done flag and command counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= EMPTY;
      armed_r <= 1'b0;
      resp_r  <= '0;
      done_r  <= 1'b0;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      // Holds off acceptance until the first edge after reset release
      armed_r <= 1'b1;
      if (io_cmd_yumi_o) begin
        resp_r <= resp_n;
        if (count_r != 32'hFFFF_FFFF) count_r <= count_r + 32'd1;
        if (is_write_c && (io_cmd_type_i == 2'd2)) done_r <= 1'b1;
      end
    end
  end

  // Storage: byte-lane merge of write data into the addressed entry
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else if (io_cmd_yumi_o && is_write_c) begin
      mem_r[idx_c] <= (entry_c & ~wmask_c) | wdata_c;
    end
  end

  assign io_resp_v_o       = (state_r == FULL);
  assign io_resp_type_o    = resp_r.typ;
  assign io_resp_addr_o    = resp_r.addr;
  assign io_resp_size_o    = resp_r.size;
  assign io_resp_data_o    = resp_r.data;
  assign io_resp_payload_o = resp_r.payload;
  assign io_resp_err_o     = resp_r.err;
  assign done_o            = done_r;
  assign cmd_count_o       = count_r;

endmodule

// File: tb/tb_bp_nbf_io_responder.sv
// Self-checking bench for bp_nbf_io_responder: a byte-level reference model
// predicts each response at acceptance and a scoreboard queue compares it on
// the response handshake.
module tb_bp_nbf_io_responder;

  localparam int unsigned ELS = 16;
  localparam int unsigned AW  = 40;
  localparam int unsigned PW  = 16;
  localparam logic [AW-1:0] BASE = 40'h00_0010_0000;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [1:0]    io_cmd_type_i;
  logic [AW-1:0] io_cmd_addr_i;
  logic [1:0]    io_cmd_size_i;
  logic [63:0]   io_cmd_data_i;
  logic [PW-1:0] io_cmd_payload_i;
  logic          io_cmd_v_i;
  logic          io_cmd_yumi_o;
  logic [1:0]    io_resp_type_o;
  logic [AW-1:0] io_resp_addr_o;
  logic [1:0]    io_resp_size_o;
  logic [63:0]   io_resp_data_o;
  logic [PW-1:0] io_resp_payload_o;
  logic          io_resp_err_o;
  logic          io_resp_v_o;
  logic          io_resp_ready_and_i;
  logic          done_o;
  logic [31:0]   cmd_count_o;

  bp_nbf_io_responder #(
    .els_p(ELS), .paddr_width_p(AW), .base_addr_p(BASE), .payload_width_p(PW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_type_i(io_cmd_type_i), .io_cmd_addr_i(io_cmd_addr_i),
    .io_cmd_size_i(io_cmd_size_i), .io_cmd_data_i(io_cmd_data_i),
    .io_cmd_payload_i(io_cmd_payload_i), .io_cmd_v_i(io_cmd_v_i),
    .io_cmd_yumi_o(io_cmd_yumi_o),
    .io_resp_type_o(io_resp_type_o), .io_resp_addr_o(io_resp_addr_o),
    .io_resp_size_o(io_resp_size_o), .io_resp_data_o(io_resp_data_o),
    .io_resp_payload_o(io_resp_payload_o), .io_resp_err_o(io_resp_err_o),
    .io_resp_v_o(io_resp_v_o), .io_resp_ready_and_i(io_resp_ready_and_i),
    .done_o(done_o), .cmd_count_o(cmd_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    typ;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [63:0]   data;
    logic [PW-1:0] payload;
    logic          err;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_mem [ELS];
  logic        exp_done;
  int unsigned exp_count;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ELS; i++) model_mem[i] = 64'd0;
    sb_q.delete();
    exp_done  = 1'b0;
    exp_count = 0;
  endtask

  // Byte-by-byte reference of one accepted command
  task automatic model_accept();
    exp_t          e;
    logic [AW-1:0] off;
    logic          inwin, mis;
    int            nb, b, idx;
    nb    = 1 << io_cmd_size_i;
    off   = io_cmd_addr_i - BASE;
    inwin = off < AW'(8 * ELS);
    mis   = (io_cmd_addr_i % AW'(nb)) != '0;
    e.typ = io_cmd_type_i;
    e.addr = io_cmd_addr_i;
    e.size = io_cmd_size_i;
    e.payload = io_cmd_payload_i;
    e.err  = !inwin || mis || (io_cmd_type_i == 2'd3);
    e.data = 64'd0;
    b   = int'(io_cmd_addr_i[2:0]);
    idx = inwin ? int'(off >> 3) : 0;
    if (!e.err) begin
      if (io_cmd_type_i == 2'd0) begin
        for (int k = 0; k < nb; k++) e.data[8*k +: 8] = model_mem[idx][8*(b+k) +: 8];
      end else begin
        for (int k = 0; k < nb; k++) model_mem[idx][8*(b+k) +: 8] = io_cmd_data_i[8*k +: 8];
        if (io_cmd_type_i == 2'd2) exp_done = 1'b1;
      end
    end
    if (exp_count != 32'hFFFF_FFFF) exp_count++;
    sb_q.push_back(e);
  endtask

  // Monitor: compare on response handshake, predict on command accept
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      if (io_resp_v_o && io_resp_ready_and_i) begin
        check("resp_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("resp_type", 64'(io_resp_type_o), 64'(e.typ));
          check("resp_addr", 64'(io_resp_addr_o), 64'(e.addr));
          check("resp_size", 64'(io_resp_size_o), 64'(e.size));
          check("resp_data", io_resp_data_o, e.data);
          check("resp_payload", 64'(io_resp_payload_o), 64'(e.payload));
          check("resp_err", 64'(io_resp_err_o), 64'(e.err));
        end
      end
      if (io_cmd_v_i && io_cmd_yumi_o) model_accept();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command from posedge+1 until it is consumed (bounded)
  task automatic send(input logic [1:0] t, input logic [AW-1:0] a, input logic [1:0] s,
                      input logic [63:0] d, input logic [PW-1:0] p, output int waited);
    io_cmd_type_i = t; io_cmd_addr_i = a; io_cmd_size_i = s;
    io_cmd_data_i = d; io_cmd_payload_i = p; io_cmd_v_i = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!io_cmd_yumi_o && waited < 50);
    check("accept", 64'(io_cmd_yumi_o), 64'(1));
    @(posedge clk);
    #1;
    io_cmd_v_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    model_reset();
    idle(2);
    reset_i = 1'b1;
    idle(2);
  endtask

  int w;

  initial begin
    model_reset();
    reset_i = 1'b0;
    io_resp_ready_and_i = 1'b1;
    io_cmd_type_i = 2'd0; io_cmd_addr_i = BASE; io_cmd_size_i = 2'd3;
    io_cmd_data_i = 64'd0; io_cmd_payload_i = '0;
    io_cmd_v_i = 1'b1;

    // Reset state, with a command already waiting
    #12;
    check("rst_yumi", 64'(io_cmd_yumi_o), 64'(0));
    check("rst_resp_v", 64'(io_resp_v_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_count", 64'(cmd_count_o), 64'(0));
    check("rst_resp_data", io_resp_data_o, 64'd0);
    check("rst_resp_addr", 64'(io_resp_addr_o), 64'(0));
    io_cmd_v_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    idle(2);

    // Full-width write/read, sub-word merge, partial reads
    send(2'd1, BASE + 40'h8, 2'd3, 64'h1122_3344_5566_7788, 16'h0A01, w);
    send(2'd0, BASE + 40'h8, 2'd3, 64'd0, 16'h0A02, w);
    send(2'd1, BASE + 40'hD, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 16'h0A03, w);
    send(2'd0, BASE + 40'h8, 2'd3, 64'd0, 16'h0A04, w);
    send(2'd0, BASE + 40'hC, 2'd1, 64'd0, 16'h0A05, w);
    send(2'd0, BASE + 40'hC, 2'd2, 64'd0, 16'h0A06, w);
    send(2'd1, BASE + 40'h7A, 2'd1, 64'h0000_0000_0000_BEEF, 16'h0A07, w);
    send(2'd0, BASE + 40'h78, 2'd3, 64'd0, 16'h0A08, w);

    // Error cases leave storage untouched and return zero data
    send(2'd0, BASE + 40'(8 * ELS), 2'd3, 64'd0, 16'h0B01, w);
    send(2'd0, BASE + 40'h2, 2'd2, 64'd0, 16'h0B02, w);
    send(2'd1, BASE + 40'hA, 2'd2, 64'hFFFF_FFFF, 16'h0B03, w);
    send(2'd3, BASE + 40'h8, 2'd3, 64'hFFFF_FFFF, 16'h0B04, w);
    send(2'd1, BASE - 40'h8, 2'd3, 64'h5555, 16'h0B05, w);
    send(2'd2, BASE + 40'h1, 2'd3, 64'h5555, 16'h0B06, w);
    send(2'd0, BASE + 40'h8, 2'd3, 64'd0, 16'h0B07, w);
    drain();
    check("count_mid", 64'(cmd_count_o), 64'(exp_count));
    check("done_idle", 64'(done_o), 64'(exp_done));

    // Back-to-back commands at full throughput
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(2'(i % 2), BASE + 40'(8 * i), 2'd3, 64'h0123_4567_89AB_CDEF + 64'(i), PW'(16'h0C00 + i), w);
      check("b2b_wait", 64'(w), 64'(1));
    end
    drain();
    check("b2b_count", 64'(cmd_count_o), 64'(4));

    // Backpressure: response holds, yumi waits for the handshake
    io_resp_ready_and_i = 1'b0;
    send(2'd0, BASE + 40'h8, 2'd3, 64'd0, 16'h0D01, w);
    io_cmd_type_i = 2'd1; io_cmd_addr_i = BASE + 40'h10; io_cmd_size_i = 2'd3;
    io_cmd_data_i = 64'hCAFE_F00D_0000_0010; io_cmd_payload_i = 16'h0D02;
    io_cmd_v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_yumi", 64'(io_cmd_yumi_o), 64'(0));
      check("hold_v", 64'(io_resp_v_o), 64'(1));
      check("hold_addr", 64'(io_resp_addr_o), 64'(sb_q[0].addr));
      check("hold_data", io_resp_data_o, sb_q[0].data);
    end
    @(posedge clk);
    #1;
    io_resp_ready_and_i = 1'b1;
    @(negedge clk);
    check("release_yumi", 64'(io_cmd_yumi_o), 64'(1));
    check("release_v", 64'(io_resp_v_o), 64'(1));
    @(posedge clk);
    #1;
    io_cmd_v_i = 1'b0;
    send(2'd0, BASE + 40'h10, 2'd3, 64'd0, 16'h0D03, w);
    drain();

    // Done-write, then asynchronous reset with the response still pending
    io_resp_ready_and_i = 1'b0;
    send(2'd2, BASE, 2'd3, 64'hDEAD_BEEF_0000_0001, 16'h0E01, w);
    check("done_set", 64'(done_o), 64'(1));
    check("done_resp_v", 64'(io_resp_v_o), 64'(1));
    check("done_count", 64'(cmd_count_o), 64'(exp_count));
    #3;
    reset_i = 1'b0;
    #1;
    check("arst_resp_v", 64'(io_resp_v_o), 64'(0));
    check("arst_done", 64'(done_o), 64'(0));
    check("arst_count", 64'(cmd_count_o), 64'(0));
    check("arst_resp_data", io_resp_data_o, 64'd0);
    model_reset();
    idle(2);
    reset_i = 1'b1;
    io_resp_ready_and_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dropped_v", 64'(io_resp_v_o), 64'(0));
    end
    @(posedge clk);
    #1;
    send(2'd0, BASE, 2'd3, 64'd0, 16'h0E02, w);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
